// File: rtl/systolic_mac_pe_if.sv
// systolic_mac_pe_if: operand / result bundle of one systolic MAC PE.
// master drives operands and observes results; slave is the PE.
interface systolic_mac_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic signed [DATA_W-1:0] weight;
    logic signed [DATA_W-1:0] feature_in;
    logic                     valid_in;
    logic signed [DATA_W-1:0] feature_out;
    logic signed [ACC_W-1:0]  accum_out;

    modport master (
        output weight,
        output feature_in,
        output valid_in,
        input  feature_out,
        input  accum_out
    );

    modport slave (
        input  weight,
        input  feature_in,
        input  valid_in,
        output feature_out,
        output accum_out
    );
endinterface

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: signed weight*feature MAC, three-stage pipeline,
// feature forwarded east one cycle later. Accumulator wraps, reset-only clear.
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input logic              clk,
    input logic              rst,
    systolic_mac_pe_if.slave pe
);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] b_q;
    logic                     v1_q;
    logic signed [DATA_W-1:0] fwd_q;
    logic signed [PROD_W-1:0] m_q;
    logic                     v2_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  m_ext;

    // Product widened to accumulator width with its sign preserved.
    assign m_ext = {{(ACC_W-PROD_W){m_q[PROD_W-1]}}, m_q};

    // Stage 1: capture operands and forward the feature every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            v1_q  <= 1'b0;
            fwd_q <= '0;
        end else begin
            a_q   <= pe.weight;
            b_q   <= pe.feature_in;
            v1_q  <= pe.valid_in;
            fwd_q <= pe.feature_in;
        end
    end

    // Stage 2: full-width signed product, valid travels alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            m_q  <= a_q * b_q;
            v2_q <= v1_q;
        end
    end

    // Stage 3: accumulate only qualified products; overflow wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (v2_q) begin
            acc_q <= acc_q + m_ext;
        end
    end

    assign pe.feature_out = fwd_q;
    assign pe.accum_out   = acc_q;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb_systolic_mac_pe: randomized and directed checks of the MAC PE
// against a queue-based reference of issued products.
module tb_systolic_mac_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(32)) bi ();
    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(20)) ni ();

    systolic_mac_pe #(.DATA_W(8), .ACC_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .pe (bi)
    );

    systolic_mac_pe #(.DATA_W(8), .ACC_W(20)) dut_n (
        .clk(clk),
        .rst(rst),
        .pe (ni)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int                 q[$];
    logic signed [31:0] sum   = '0;
    logic signed [19:0] sum_n = '0;
    logic signed [7:0]  exp_fwd = '0;

    // One clock: drive both PEs, then advance the reference model.
    task automatic cyc(input logic signed [7:0] w,
                       input logic signed [7:0] f,
                       input logic v);
        int c;
        bi.weight = w;
        bi.feature_in = f;
        bi.valid_in = v;
        ni.weight = w;
        ni.feature_in = f;
        ni.valid_in = v;
        @(posedge clk);
        if (rst) begin
            q.delete();
            sum = '0;
            sum_n = '0;
            exp_fwd = '0;
        end else begin
            q.push_back(v ? int'(w) * int'(f) : 0);
            if (q.size() > 2) begin
                c = q.pop_front();
                sum = sum + c;
                sum_n = sum_n + 20'(c);
            end
            exp_fwd = f;
        end
        #1;
    endtask

    task automatic rnd_cyc(input logic v);
        cyc(8'($urandom), 8'($urandom), v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rnd_cyc(1'b1);
        rnd_cyc(1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_cyc(1'($urandom));
            n_chk++;
            if (bi.feature_out !== 8'sd0)
                $display("FAIL reset_fwd: got %0d want 0", bi.feature_out);
            else
                n_pass++;
            n_chk++;
            if (bi.accum_out !== 32'sd0)
                $display("FAIL reset_acc: got %0d want 0", bi.accum_out);
            else
                n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic signed [7:0]  fs [7];
        logic signed [31:0] ex [7];
        fs = '{8'sd1, 8'sd2, 8'sd3, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        ex = '{0, 0, 5, 15, 30, 30, 30};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(8'sd5, fs[i], 1'b1);
            n_chk++;
            if (bi.accum_out !== ex[i])
                $display("FAIL basic[%0d]: got %0d want %0d",
                         i, bi.accum_out, ex[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_bubbles();
        logic signed [7:0]  fs [6];
        logic               vs [6];
        logic signed [31:0] ex [6];
        fs = '{8'sd4, 8'sd9, 8'sd2, 8'sd9, 8'sd9, 8'sd9};
        vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ex = '{0, 0, 20, 20, 30, 30};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(8'sd5, fs[i], vs[i]);
            n_chk++;
            if (bi.accum_out !== ex[i])
                $display("FAIL bubbles[%0d]: got %0d want %0d",
                         i, bi.accum_out, ex[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_signed();
        do_reset();
        cyc(-8'sd3, 8'sd4, 1'b1);
        cyc(-8'sd128, -8'sd128, 1'b1);
        cyc(8'sd0, 8'sd0, 1'b0);
        n_chk++;
        if (bi.accum_out !== -32'sd12)
            $display("FAIL signed_neg: got %0d want -12", bi.accum_out);
        else
            n_pass++;
        cyc(8'sd0, 8'sd0, 1'b0);
        n_chk++;
        if (bi.accum_out !== 32'sd16372)
            $display("FAIL signed_max: got %0d want 16372", bi.accum_out);
        else
            n_pass++;
    endtask

    task automatic test_forwarding();
        logic signed [7:0] fs [3];
        fs = '{8'sd7, -8'sd1, -8'sd128};
        for (int i = 0; i < 3; i++) begin
            cyc(8'($urandom), fs[i], 1'($urandom));
            n_chk++;
            if (bi.feature_out !== fs[i])
                $display("FAIL fwd[%0d]: got %0d want %0d",
                         i, bi.feature_out, fs[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rnd_cyc($urandom_range(0, 3) != 0);
            n_chk++;
            if (bi.accum_out !== sum)
                $display("FAIL rand_acc[%0d]: got %0d want %0d",
                         i, bi.accum_out, sum);
            else
                n_pass++;
            n_chk++;
            if (bi.feature_out !== exp_fwd)
                $display("FAIL rand_fwd[%0d]: got %0d want %0d",
                         i, bi.feature_out, exp_fwd);
            else
                n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(8'sd127, 8'sd127, 1'b1);
            n_chk++;
            if (ni.accum_out !== sum_n)
                $display("FAIL wrap_run[%0d]: got %0d want %0d",
                         i, ni.accum_out, sum_n);
            else
                n_pass++;
        end
        for (int i = 0; i < 3; i++) cyc(8'sd0, 8'sd0, 1'b0);
        n_chk++;
        if (ni.accum_out !== -20'sd403416)
            $display("FAIL wrap_narrow: got %0d want -403416",
                     ni.accum_out);
        else
            n_pass++;
        n_chk++;
        if (bi.accum_out !== 32'sd645160)
            $display("FAIL wrap_wide: got %0d want 645160", bi.accum_out);
        else
            n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 6; i++) rnd_cyc(1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bi.accum_out !== 32'sd0)
            $display("FAIL midrst_acc: got %0d want 0", bi.accum_out);
        else
            n_pass++;
        n_chk++;
        if (bi.feature_out !== 8'sd0)
            $display("FAIL midrst_fwd: got %0d want 0", bi.feature_out);
        else
            n_pass++;
        q.delete();
        sum = '0;
        sum_n = '0;
        exp_fwd = '0;
        rnd_cyc(1'b1);
        rnd_cyc(1'b1);
        rst = 1'b0;
        cyc(8'sd3, 8'sd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(8'sd0, 8'sd0, 1'b0);
            n_chk++;
            if (bi.accum_out !== sum)
                $display("FAIL midrst_post[%0d]: got %0d want %0d",
                         i, bi.accum_out, sum);
            else
                n_pass++;
        end
        n_chk++;
        if (bi.accum_out !== 32'sd6)
            $display("FAIL midrst_final: got %0d want 6", bi.accum_out);
        else
            n_pass++;
    endtask

    initial begin
        bi.weight = '0;
        bi.feature_in = '0;
        bi.valid_in = 1'b0;
        ni.weight = '0;
        ni.feature_in = '0;
        ni.valid_in = 1'b0;
        #1;
        test_reset();
        test_basic_stream();
        test_bubbles();
        test_signed();
        test_forwarding();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
